// File: rtl/lsu_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_ctrl_if : request/response channel between the execute stage and the
// load/store control stage.
//
//   req_valid  master->slave  request present
//   req_ready  slave->master  slave can accept a request
//   req_wr     master->slave  1 = store, 0 = load
//   req_size   master->slave  00 byte, 01 half-word, 10 word, 11 illegal
//   req_sx     master->slave  1 = sign-extend load result
//   req_addr   master->slave  byte address
//   req_wdata  master->slave  store data, little-endian
//   resp_valid slave->master  one-cycle completion pulse
//   resp_err   slave->master  access faulted (qualifies resp_valid)
//   resp_rdata slave->master  extended load data, 0 for stores and faults
// -----------------------------------------------------------------------------
interface lsu_ctrl_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_wr;
  logic [1:0]           req_size;
  logic                 req_sx;
  logic [BUS_WIDTH-1:0] req_addr;
  logic [BUS_WIDTH-1:0] req_wdata;
  logic                 resp_valid;
  logic                 resp_err;
  logic [BUS_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_wr, req_size, req_sx, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_size, req_sx, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl : load/store control stage in front of a byte-addressable data
// memory with combinational read data. Takes one request at a time, drives the
// memory for one or more beats, reassembles/extends load data and returns a
// one-cycle response.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous, active-low reset
//   bus           lsu_ctrl_if.slave request/response channel
//   mem_address   memory byte address
//   mem_data_in   memory write data
//   mem_wr_en     memory write enable (held for the whole beat cycle)
//   mem_size      memory access size (00 byte, 01 half, 10 word)
//   mem_sz_ex     memory sign-extend select
//   mem_data_out  memory combinational read data
//
// Build option
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses fault
//                         instead of being split into byte beats.
//
// Lane assembly and extension assume BUS_WIDTH = 32.
// -----------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int BUS_WIDTH = 32,
  parameter int MEM_LIMIT = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  lsu_ctrl_if.slave            bus,
  output logic [BUS_WIDTH-1:0] mem_address,
  output logic [BUS_WIDTH-1:0] mem_data_in,
  output logic                 mem_wr_en,
  output logic [1:0]           mem_size,
  output logic                 mem_sz_ex,
  input  logic [BUS_WIDTH-1:0] mem_data_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BEAT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]           state;
  logic [2:0]           cnt;
  logic [BUS_WIDTH-1:0] asm_q;
  logic                 err_q;
  logic                 resp_valid_q;
  logic                 resp_err_q;
  logic [BUS_WIDTH-1:0] resp_rdata_q;

  // Latched request (data only, no reset needed)
  logic                 wr_q;
  logic [1:0]           size_q;
  logic                 sx_q;
  logic [BUS_WIDTH-1:0] addr_q;
  logic [BUS_WIDTH-1:0] wdata_q;
  logic                 split_q;
  logic [2:0]           nbeats_q;

  // Request decode
  logic [2:0]           nbytes;
  logic                 misaligned;
  logic [BUS_WIDTH:0]   last_byte;
  logic                 fault;
  logic                 accept;
  logic [7:0]           wbyte;

  function automatic logic [BUS_WIDTH-1:0] extend(
    input logic [1:0]           size,
    input logic                 sx,
    input logic [BUS_WIDTH-1:0] raw
  );
    logic fill8;
    logic fill16;
    fill8  = sx & raw[7];
    fill16 = sx & raw[15];
    case (size)
      2'b00:   extend = {{(BUS_WIDTH-8){fill8}}, raw[7:0]};
      2'b01:   extend = {{(BUS_WIDTH-16){fill16}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  assign accept = (state == IDLE) && bus.req_valid;

  always_comb begin
    case (bus.req_size)
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd1;
    endcase
    misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    // One extra bit so an address that wraps past the top still faults
    last_byte  = {1'b0, bus.req_addr} + (BUS_WIDTH+1)'(nbytes) - (BUS_WIDTH+1)'(1);
    fault      = (bus.req_size == 2'b11) || (last_byte >= (BUS_WIDTH+1)'(MEM_LIMIT));
`ifdef LSU_MISALIGN_TRAP_EN
    fault      = fault || misaligned;
`else
    fault      = fault;
`endif
  end

  // Accept stage: capture request fields
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q     <= bus.req_wr;
      size_q   <= bus.req_size;
      sx_q     <= bus.req_sx;
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
      split_q  <= misaligned;
      nbeats_q <= misaligned ? nbytes : 3'd1;
    end
  end

  // Control: state, beat counter, assembly and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      asm_q        <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= 3'd0;
            asm_q <= '0;
            err_q <= fault;
            state <= fault ? RESP : BEAT;
          end
        end
        BEAT: begin
          if (!wr_q) begin
            if (split_q) begin
              for (int k = 0; k < 4; k++) begin
                if (cnt[1:0] == 2'(k)) asm_q[8*k +: 8] <= mem_data_out[7:0];
              end
            end else begin
              asm_q <= mem_data_out;
            end
          end
          cnt <= cnt + 3'd1;
          if (cnt == nbeats_q - 3'd1) state <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= err_q;
          resp_rdata_q <= (err_q || wr_q) ? '0 : extend(size_q, sx_q, asm_q);
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat stage: memory drive, combinational from state so reset drops wr_en at once
  always_comb begin
    case (cnt[1:0])
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
    mem_wr_en   = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    mem_size    = 2'b10;
    mem_sz_ex   = 1'b0;
    if (state == BEAT) begin
      mem_wr_en = wr_q;
      if (split_q) begin
        mem_size    = 2'b00;
        mem_address = addr_q + BUS_WIDTH'(cnt);
        mem_data_in = BUS_WIDTH'(wbyte);
      end else begin
        mem_size    = size_q;
        mem_sz_ex   = sx_q;
        mem_address = addr_q;
        mem_data_in = wdata_q;
      end
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl : directed bench for lsu_ctrl with a 256-byte behavioural data
// memory attached to the mem_* ports.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_wr_en;
  logic [1:0]  mem_size;
  logic        mem_sz_ex;
  logic [31:0] mem_data_out;

  lsu_ctrl_if #(.BUS_WIDTH(32)) bus ();

  lsu_ctrl #(.BUS_WIDTH(32), .MEM_LIMIT(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_wr_en    (mem_wr_en),
    .mem_size     (mem_size),
    .mem_sz_ex    (mem_sz_ex),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural data memory
  bit [7:0]    mem [256];
  int          wr_cycles = 0;
  logic [31:0] raw;

  always_comb begin
    raw = {mem[8'(mem_address + 32'd3)], mem[8'(mem_address + 32'd2)],
           mem[8'(mem_address + 32'd1)], mem[mem_address[7:0]]};
    case (mem_size)
      2'b00:   mem_data_out = mem_sz_ex ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
      2'b01:   mem_data_out = mem_sz_ex ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
      default: mem_data_out = raw;
    endcase
  end

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_address[7:0]] <= mem_data_in[7:0];
      if (mem_size != 2'b00) mem[8'(mem_address + 32'd1)] <= mem_data_in[15:8];
      if (mem_size == 2'b10) begin
        mem[8'(mem_address + 32'd2)] <= mem_data_in[23:16];
        mem[8'(mem_address + 32'd3)] <= mem_data_in[31:24];
      end
      wr_cycles <= wr_cycles + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  // Per-transaction observation filled by do_req
  int          lat;
  int          beats;
  logic        busy_ready;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] log_addr [8];
  logic [31:0] log_data [8];
  logic [1:0]  log_size [8];
  logic        log_wr   [8];

  task automatic do_req(input logic wr, input logic [1:0] size, input logic sx,
                        input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_size  = size;
    bus.req_sx    = sx;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = -1; beats = 0; busy_ready = 1'b0; rdata = 32'hx; err = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      if (mem_wr_en || mem_size != 2'b10 || mem_address != 0 || mem_data_in != 0) begin
        if (beats < 8) begin
          log_addr[beats] = mem_address;
          log_data[beats] = mem_data_in;
          log_size[beats] = mem_size;
          log_wr[beats]   = mem_wr_en;
        end
        beats++;
      end
      if (bus.req_ready) busy_ready = 1'b1;
      @(posedge clk); #1;
      if (bus.resp_valid) begin
        lat   = n;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_size = 2'b00;
    bus.req_sx = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b exp=0", bus.resp_err); end
    checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.resp_rdata); end
    checks++; if ({mem_wr_en, mem_size, mem_address} !== {1'b0, 2'b10, 32'h0}) begin
      errors++; $display("FAIL reset_mem_idle got=%b/%b/%h exp=0/10/0", mem_wr_en, mem_size, mem_address); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_aligned();
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    checks++; if (lat !== 2) begin errors++; $display("FAIL st_w_latency got=%0d exp=2", lat); end
    checks++; if (beats !== 1) begin errors++; $display("FAIL st_w_beats got=%0d exp=1", beats); end
    checks++; if ({log_wr[0], log_size[0], log_addr[0], log_data[0]} !== {1'b1, 2'b10, 32'h10, 32'hDEADBEEF}) begin
      errors++; $display("FAIL st_w_beat got=%b/%b/%h/%h exp=1/10/10/deadbeef", log_wr[0], log_size[0], log_addr[0], log_data[0]); end
    checks++; if ({err, rdata} !== {1'b0, 32'h0}) begin errors++; $display("FAIL st_w_resp got=%b/%h exp=0/0", err, rdata); end
    checks++; if (busy_ready !== 1'b0) begin errors++; $display("FAIL st_w_busy_ready got=%b exp=0", busy_ready); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ld_w_latency got=%0d exp=2", lat); end
    checks++; if ({err, rdata} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL ld_w_resp got=%b/%h exp=0/deadbeef", err, rdata); end
    checks++; if ({log_wr[0], log_size[0]} !== {1'b0, 2'b10}) begin errors++; $display("FAIL ld_w_beat got=%b/%b exp=0/10", log_wr[0], log_size[0]); end
  endtask

  task automatic test_misaligned_word();
`ifndef LSU_MISALIGN_TRAP_EN
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h44; exp_b[1] = 8'h33; exp_b[2] = 8'h22; exp_b[3] = 8'h11;
    do_req(1'b1, 2'b10, 1'b0, 32'h21, 32'h11223344);
    checks++; if (lat !== 5) begin errors++; $display("FAIL st_mw_latency got=%0d exp=5", lat); end
    checks++; if (beats !== 4) begin errors++; $display("FAIL st_mw_beats got=%0d exp=4", beats); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({log_wr[k], log_size[k], log_addr[k], log_data[k]} !== {1'b1, 2'b00, 32'h21 + 32'(k), 24'h0, exp_b[k]}) begin
        errors++; $display("FAIL st_mw_beat%0d got=%b/%b/%h/%h exp=1/00/%h/%h", k,
                           log_wr[k], log_size[k], log_addr[k], log_data[k], 32'h21 + 32'(k), exp_b[k]);
      end
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h21, 32'h0);
    checks++; if (lat !== 5) begin errors++; $display("FAIL ld_mw_latency got=%0d exp=5", lat); end
    checks++; if ({err, rdata} !== {1'b0, 32'h11223344}) begin errors++; $display("FAIL ld_mw_resp got=%b/%h exp=0/11223344", err, rdata); end
`endif
  endtask

  task automatic test_half_extend();
`ifndef LSU_MISALIGN_TRAP_EN
    do_req(1'b1, 2'b01, 1'b0, 32'h31, 32'h000080F0);
    checks++; if ({lat, beats} !== {32'd3, 32'd2}) begin errors++; $display("FAIL st_mh_lat_beats got=%0d/%0d exp=3/2", lat, beats); end
    do_req(1'b0, 2'b01, 1'b1, 32'h31, 32'h0);
    checks++; if ({lat, beats} !== {32'd3, 32'd2}) begin errors++; $display("FAIL ld_mh_sx_lat_beats got=%0d/%0d exp=3/2", lat, beats); end
    checks++; if (rdata !== 32'hFFFF80F0) begin errors++; $display("FAIL ld_mh_sx got=%h exp=ffff80f0", rdata); end
    do_req(1'b0, 2'b01, 1'b0, 32'h31, 32'h0);
    checks++; if (rdata !== 32'h000080F0) begin errors++; $display("FAIL ld_mh_zx got=%h exp=000080f0", rdata); end
    do_req(1'b0, 2'b00, 1'b1, 32'h32, 32'h0);
    checks++; if ({lat, rdata} !== {32'd2, 32'hFFFFFF80}) begin errors++; $display("FAIL ld_b_sx got=%0d/%h exp=2/ffffff80", lat, rdata); end
`endif
  endtask

  task automatic test_faults();
    int wr0;
    wr0 = wr_cycles;
    do_req(1'b0, 2'b10, 1'b0, 32'hFE, 32'h0);
    checks++; if ({lat, err, rdata} !== {32'd1, 1'b1, 32'h0}) begin errors++; $display("FAIL flt_ld_fe got=%0d/%b/%h exp=1/1/0", lat, err, rdata); end
    checks++; if (beats !== 0) begin errors++; $display("FAIL flt_ld_fe_beats got=%0d exp=0", beats); end
    do_req(1'b1, 2'b11, 1'b0, 32'h00, 32'hCAFEF00D);
    checks++; if ({lat, err, rdata} !== {32'd1, 1'b1, 32'h0}) begin errors++; $display("FAIL flt_size11 got=%0d/%b/%h exp=1/1/0", lat, err, rdata); end
    do_req(1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h1234);
    checks++; if ({lat, err} !== {32'd1, 1'b1}) begin errors++; $display("FAIL flt_wrap got=%0d/%b exp=1/1", lat, err); end
    checks++; if (wr_cycles !== wr0) begin errors++; $display("FAIL flt_no_write got=%0d exp=%0d", wr_cycles, wr0); end
    do_req(1'b1, 2'b10, 1'b0, 32'hFC, 32'h89ABCDEF);
    checks++; if ({lat, err} !== {32'd2, 1'b0}) begin errors++; $display("FAIL edge_fc_store got=%0d/%b exp=2/0", lat, err); end
    do_req(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0);
    checks++; if ({err, rdata} !== {1'b0, 32'h89ABCDEF}) begin errors++; $display("FAIL edge_fc_load got=%b/%h exp=0/89abcdef", err, rdata); end
  endtask

  task automatic test_reset_mid_store();
`ifndef LSU_MISALIGN_TRAP_EN
    int resp_seen;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_size = 2'b10;
    bus.req_sx = 1'b0; bus.req_addr = 32'h41; bus.req_wdata = 32'hA1B2C3D4;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if ({mem_wr_en, mem_address} !== {1'b1, 32'h43}) begin
      errors++; $display("FAIL rst_mid_beat2 got=%b/%h exp=1/43", mem_wr_en, mem_address); end
    rst = 1'b0;
    #1;
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL rst_mid_wr_en got=%b exp=0", mem_wr_en); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_idle got=%b exp=1", bus.req_ready); end
    @(negedge clk); rst = 1'b1;
    resp_seen = 0;
    repeat (6) begin @(posedge clk); #1; if (bus.resp_valid) resp_seen++; end
    checks++; if (resp_seen !== 0) begin errors++; $display("FAIL rst_mid_no_resp got=%0d exp=0", resp_seen); end
    checks++; if ({mem[8'h41], mem[8'h42], mem[8'h43], mem[8'h44]} !== 32'hD4C30000) begin
      errors++; $display("FAIL rst_mid_bytes got=%h%h%h%h exp=d4c30000", mem[8'h41], mem[8'h42], mem[8'h43], mem[8'h44]); end
`endif
  endtask

  task automatic test_misalign_mode();
    do_req(1'b0, 2'b01, 1'b0, 32'h05, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if ({lat, err, beats} !== {32'd1, 1'b1, 32'd0}) begin errors++; $display("FAIL trap_h05 got=%0d/%b/%0d exp=1/1/0", lat, err, beats); end
`else
    checks++; if ({lat, err, beats} !== {32'd3, 1'b0, 32'd2}) begin errors++; $display("FAIL split_h05 got=%0d/%b/%0d exp=3/0/2", lat, err, beats); end
`endif
    do_req(1'b0, 2'b01, 1'b0, 32'h06, 32'h0);
    checks++; if ({lat, err, beats} !== {32'd2, 1'b0, 32'd1}) begin errors++; $display("FAIL aligned_h06 got=%0d/%b/%0d exp=2/0/1", lat, err, beats); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_misaligned_word();
    test_half_extend();
    test_faults();
    test_reset_mid_store();
    test_misalign_mode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
